multiword_addsub_ctrl: RTL
==========================

Name: multiword_addsub_ctrl

Overview:
- Nibble-serial controller that performs WIDTH = 4*NIBBLES-bit two's-complement add/subtract by reusing one 4-bit add/sub slice over NIBBLES cycles, LSB nibble first.
- A registered carry chains the slices.
- Valid/ready handshake on the command side and on the result side.
- Sits between the operand register file and the status/flag logic of the arithmetic unit; it trades latency for area against a full-width adder.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width WIDTH = 4*NIBBLES; legal values 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  command valid
- start_ready  output  1  controller can accept a command (high only in IDLE)
- op_a  input  WIDTH  operand A, captured on start handshake
- op_b  input  WIDTH  operand B, captured on start handshake
- mode  input  1  0 = A+B, 1 = A-B; captured on start handshake
- result  output  WIDTH  sum/difference, valid while done_valid
- carry_out  output  1  final slice carry; for subtract, 1 = no borrow (A >= B unsigned)
- overflow  output  1  signed overflow of the full-width operation
- done_valid  output  1  result/flags valid; held until accepted
- done_ready  input  1  consumer accepts result
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, start_ready=1, done_valid=0, busy=0, result=0, carry_out=0, overflow=0, internal index=0, carry register=0.
- States:
  - IDLE: start_ready=1. On start_valid&start_ready: register op_a, op_b and mode; load carry register with mode (the +1 for subtract); clear index; go to RUN. Otherwise stay.
  - RUN: each cycle, slice i = index computes a[i] + (mode ? ~b[i] : b[i]) + carry. Write the 4-bit sum into result[4i+3:4i]. Update the carry register with the slice carry. Increment index.
    - On the last slice (index = NIBBLES-1): carry_out = slice carry; overflow = carry into bit 3 XOR carry out of bit 3 of that slice; go to DONE.
  - DONE: done_valid=1. result/carry_out/overflow stay stable until done_valid&done_ready, then go to IDLE.
- Latency: start handshake to done_valid asserted is exactly NIBBLES+1 clock edges (1 capture edge + NIBBLES RUN edges). Next start is accepted no earlier than the cycle after the done handshake (one-cycle bubble minimum).
- Arithmetic: modulo 2^WIDTH; operands are two's complement for overflow, unsigned for carry_out.
- start_valid is ignored outside IDLE; no buffering of a second command.
- done_ready may be high before done_valid; it has no effect outside DONE.
- Result bits of not-yet-processed nibbles are unspecified during RUN. Consumers sample only when done_valid=1.
- rst_n asserted mid-RUN or in DONE: immediate return to reset values. The pending operation is discarded and no done_valid is produced.
- op_a/op_b/mode changing after the start handshake has no effect on the in-flight operation.

Optional Feature:
- Macro: MULTIWORD_ADDSUB_SATURATE_EN.
- Defined: when overflow=1 in DONE, result is clamped to signed max 0x7F..F (if the true result is positive, i.e. A sign = 0) or signed min 0x80..0 (A sign = 1). overflow still reports 1; carry_out is unchanged.
- Not defined: result is the wrapped modulo value. No extra ports either way.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/DONE), mode constants (MODE_ADD=0, MODE_SUB=1), slice width constant 4.
- Sub-module: nibble_addsub_slice, a combinational 4-bit a+b'+cin returning sum[3:0], cout and c3 (carry into MSB). Instantiated once and time-multiplexed by the controller.

Test Plan (NIBBLES=4):
- Add 0x1234 + 0x0FFF -> result 0x2233, carry_out 0, overflow 0; done_valid exactly 5 edges after the handshake.
- Add 0x7FFF + 0x0001 -> result 0x8000, overflow 1, carry_out 0. With SATURATE_EN: result 0x7FFF.
- Sub 0x8000 - 0x0001 -> result 0x7FFF, overflow 1, carry_out 1. With SATURATE_EN: result 0x8000.
- Sub 0x0003 - 0x0005 -> result 0xFFFE, overflow 0, carry_out 0 (borrow); then add 0xFFFF + 0x0001 -> result 0x0000, carry_out 1, overflow 0.
- Backpressure: hold done_ready=0 for 10 cycles -> done_valid, result and flags stay stable, start_ready=0, and a new start_valid is ignored. Release done_ready -> IDLE next cycle; the next command is accepted.
- Reset: pulse rst_n low on the 2nd RUN cycle of 0x1111+0x2222 -> all outputs return to reset values immediately, and no done_valid occurs. A following command 0x0001+0x0001 completes with result 0x0002.

Source files
------------

// File: rtl/multiword_addsub_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller:
// FSM state encoding, mode encoding and the width of the reused slice.
package multiword_addsub_ctrl_pkg;

    localparam int SLICE_W = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit slice: sum = a + (invert_b ? ~b : b) + cin.
// c3 is the carry into the slice MSB, used for signed overflow detection.
module nibble_addsub_slice
    import multiword_addsub_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               invert_b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c3
);

    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W:0]   total;
    logic [SLICE_W-1:0] low;

    // Full slice sum plus a separate sum of the lower bits to expose the MSB carry-in.
    always_comb begin
        b_eff = invert_b ? ~b : b;
        total = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};
        low   = {1'b0, a[SLICE_W-2:0]} + {1'b0, b_eff[SLICE_W-2:0]}
              + {{(SLICE_W-1){1'b0}}, cin};
        sum   = total[SLICE_W-1:0];
        cout  = total[SLICE_W];
        c3    = low[SLICE_W-1];
    end

endmodule

// File: rtl/multiword_addsub_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract controller. One 4-bit slice is reused
// over NIBBLES cycles, LSB nibble first, with a registered carry between slices.
// Optional macro MULTIWORD_ADDSUB_SATURATE_EN clamps the result to signed
// max/min when the full-width operation overflows.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a command; start_ready high
// ST_RUN  | processing nibble idx, one slice per clock
// ST_DONE | result and flags held with done_valid until done_ready
module multiword_addsub_ctrl
    import multiword_addsub_ctrl_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = SLICE_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mode,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int             IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0]  LAST = IW'(NIBBLES - 1);
`ifdef MULTIWORD_ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               mode_q;
    logic               carry_q;
    logic [IW-1:0]      idx;

    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] s_nib;
    logic               s_cout;
    logic               s_c3;

    // Select the current nibble of each captured operand for the shared slice.
    always_comb begin
        a_nib = a_q[idx*SLICE_W +: SLICE_W];
        b_nib = b_q[idx*SLICE_W +: SLICE_W];
    end

    nibble_addsub_slice u_slice (
        .a        (a_nib),
        .b        (b_nib),
        .invert_b (mode_q == MODE_SUB),
        .cin      (carry_q),
        .sum      (s_nib),
        .cout     (s_cout),
        .c3       (s_c3)
    );

    // Controller FSM with registered handshake outputs and result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
            busy        <= 1'b0;
            result      <= '0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            carry_q     <= 1'b0;
            idx         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_q         <= op_a;
                        b_q         <= op_b;
                        mode_q      <= mode;
                        carry_q     <= mode;
                        idx         <= '0;
                        state       <= ST_RUN;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ST_RUN: begin
                    result[idx*SLICE_W +: SLICE_W] <= s_nib;
                    carry_q <= s_cout;
                    idx     <= idx + IW'(1);
                    if (idx == LAST) begin
                        carry_out  <= s_cout;
                        overflow   <= s_c3 ^ s_cout;
                        state      <= ST_DONE;
                        done_valid <= 1'b1;
`ifdef MULTIWORD_ADDSUB_SATURATE_EN
                        // On overflow the true result has the sign of A.
                        if (s_c3 ^ s_cout) begin
                            result <= a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
                        end
`endif
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        state       <= ST_IDLE;
                        done_valid  <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    start_ready <= 1'b1;
                    done_valid  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
